// File: rtl/scope_pkg.sv
// scope_pkg: frame-buffer geometry, colours and writer state encoding shared with the VGA scan-out.
package scope_pkg;

    localparam int FB_W     = 640;
    localparam int FB_H     = 480;
    localparam int ADDR_W   = 19;
    localparam int SAMPLE_W = 8;
    localparam int ROW_W    = 10;
    localparam int COL_W    = 10;

    localparam logic [11:0] COLOR_BLACK = 12'h000;
    localparam logic [11:0] COLOR_GREEN = 12'h010;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WRITE,
        DONE
    } state_t;

endpackage

// File: rtl/sample_to_row.sv
// sample_to_row: maps a sample code to its centre row and the clipped trace band around it.
module sample_to_row #(
    parameter int FB_H     = 480,
    parameter int SAMPLE_W = 8,
    parameter int THICK    = 3
) (
    input  logic [SAMPLE_W-1:0]          sample,
    output logic [scope_pkg::ROW_W-1:0]  centre,
    output logic [scope_pkg::ROW_W-1:0]  band_lo,
    output logic [scope_pkg::ROW_W-1:0]  band_hi
);

    localparam int RW   = scope_pkg::ROW_W;
    localparam int PW   = SAMPLE_W + 9;
    localparam int HALF = (THICK - 1) / 2;

    logic [PW-1:0] prod;
    logic [RW:0]   hi_ext;

    // Full-width product so the shift sees every bit; code 0 lands on the bottom row.
    always_comb begin
        prod    = PW'(sample) * PW'(FB_H - 1);
        centre  = RW'(FB_H - 1) - RW'(prod >> SAMPLE_W);
        band_lo = (centre < RW'(HALF)) ? '0 : centre - RW'(HALF);
        hi_ext  = {1'b0, centre} + (RW + 1)'(HALF);
        band_hi = (hi_ext > (RW + 1)'(FB_H - 1)) ? RW'(FB_H - 1) : hi_ext[RW-1:0];
    end

endmodule

// File: rtl/trace_column_writer.sv
// trace_column_writer: renders one sample per column into the frame buffer during vblank.
module trace_column_writer #(
    parameter int          FB_W        = scope_pkg::FB_W,
    parameter int          FB_H        = scope_pkg::FB_H,
    parameter int          ADDR_W      = scope_pkg::ADDR_W,
    parameter int          SAMPLE_W    = scope_pkg::SAMPLE_W,
    parameter int          THICK       = 3,
    parameter logic [11:0] TRACE_COLOR = scope_pkg::COLOR_GREEN,
    parameter logic [11:0] BG_COLOR    = scope_pkg::COLOR_BLACK
) (
    input  logic                clk_25MHz,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] sample_data,
    input  logic                sample_valid,
    output logic                sample_ready,
    input  logic                freeze,
    input  logic                vblank,
    output logic                fb_we,
    output logic [ADDR_W-1:0]   fb_addr,
    output logic [11:0]         fb_wdata,
    output logic [9:0]          wr_col,
    output logic                col_done
);

    import scope_pkg::*;

    state_t              state, state_next;
    logic [SAMPLE_W-1:0] sample_q;
    logic [ROW_W-1:0]    row, centre, centre_q, lo, lo_q, hi, hi_q;
    logic [ADDR_W-1:0]   addr;
    logic                accept, in_band;

    sample_to_row #(
        .FB_H     (FB_H),
        .SAMPLE_W (SAMPLE_W),
        .THICK    (THICK)
    ) u_map (
        .sample  (sample_q),
        .centre  (centre),
        .band_lo (lo),
        .band_hi (hi)
    );

    always_comb begin
        sample_ready = (state == IDLE) && !freeze && !rst;
        accept       = sample_valid && sample_ready;
        fb_we        = (state == WRITE) && vblank && !rst;
        in_band      = (row >= lo_q) && (row <= hi_q);
        fb_addr      = addr;
        fb_wdata     = (fb_we && in_band) ? TRACE_COLOR : BG_COLOR;
        col_done     = (state == DONE);
        state_next   = (state == IDLE)  ? (accept ? LOAD : IDLE) :
                       (state == LOAD)  ? WRITE :
                       (state == WRITE) ? ((fb_we && row == ROW_W'(FB_H - 1)) ? DONE : WRITE) :
                                          IDLE;
    end

    // Row address steps by a frame width per write instead of multiplying row*FB_W.
    always_ff @(posedge clk_25MHz) begin
        if (rst) begin
            state    <= IDLE;
            sample_q <= '0;
            centre_q <= '0;
            lo_q     <= '0;
            hi_q     <= '0;
            row      <= '0;
            addr     <= '0;
            wr_col   <= '0;
        end else begin
            state <= state_next;
            if (accept)
                sample_q <= sample_data;
            if (state == LOAD) begin
                centre_q <= centre;
                lo_q     <= lo;
                hi_q     <= hi;
                row      <= '0;
                addr     <= ADDR_W'(wr_col);
            end
            if (fb_we) begin
                row  <= row + ROW_W'(1);
                addr <= addr + ADDR_W'(FB_W);
            end
            if (state == DONE)
                wr_col <= (wr_col == 10'(FB_W - 1)) ? '0 : wr_col + 10'd1;
        end
    end

    assert property (@(posedge clk_25MHz) disable iff (rst)
        state == WRITE |-> (lo_q <= centre_q && centre_q <= hi_q));

endmodule

// File: tb/tb_trace_column_writer.sv
// tb_trace_column_writer: directed column-rendering checks with hand-computed trace bands.
module tb_trace_column_writer;

    logic        clk = 0;
    logic        rst, sample_valid, freeze, vblank;
    logic [7:0]  sample_data;
    logic        sample_ready, fb_we, col_done;
    logic [18:0] fb_addr;
    logic [11:0] fb_wdata;
    logic [9:0]  wr_col;

    logic        s_valid, s_vblank, s_freeze, s_ready, s_we, s_done;
    logic [7:0]  s_data;
    logic [3:0]  s_addr;
    logic [11:0] s_wdata;
    logic [9:0]  s_col;

    int total = 0, bad = 0;
    int nwr, first_k, done_k, addr_errs, data_errs, we_low_errs, ready_errs;

    always #20 clk = ~clk;

    trace_column_writer dut (
        .clk_25MHz    (clk),
        .rst          (rst),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .freeze       (freeze),
        .vblank       (vblank),
        .fb_we        (fb_we),
        .fb_addr      (fb_addr),
        .fb_wdata     (fb_wdata),
        .wr_col       (wr_col),
        .col_done     (col_done)
    );

    // Tiny 5x3 frame so the column wrap is reachable in a short run.
    trace_column_writer #(.FB_W(5), .FB_H(3), .ADDR_W(4), .THICK(1)) dut_s (
        .clk_25MHz    (clk),
        .rst          (rst),
        .sample_data  (s_data),
        .sample_valid (s_valid),
        .sample_ready (s_ready),
        .freeze       (s_freeze),
        .vblank       (s_vblank),
        .fb_we        (s_we),
        .fb_addr      (s_addr),
        .fb_wdata     (s_wdata),
        .wr_col       (s_col),
        .col_done     (s_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] s);
        int n = 0;
        @(negedge clk);
        #1;
        while (!sample_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("send_ready", 32'(sample_ready), 1);
        sample_data  = s;
        sample_valid = 1;
        @(negedge clk);
        sample_valid = 0;
    endtask

    task automatic watch(input int col, input int lo, input int hi, input bit toggle,
                         input int stop_at, input int freeze_k);
        nwr = 0; first_k = -1; done_k = -1;
        addr_errs = 0; data_errs = 0; we_low_errs = 0; ready_errs = 0;
        for (int k = 0; k < 2000; k++) begin
            if (toggle) vblank = ((k / 10) % 2) == 0;
            if (k == freeze_k) begin
                freeze = 1; sample_valid = 1; sample_data = 8'd10;
            end
            #1;
            if (sample_ready) ready_errs++;
            if (fb_we && !vblank) we_low_errs++;
            if (fb_we) begin
                if (first_k < 0) first_k = k;
                if (fb_addr !== 19'(col + nwr * 640)) addr_errs++;
                if (fb_wdata !== ((nwr >= lo && nwr <= hi) ? 12'h010 : 12'h000)) data_errs++;
                nwr++;
                if (nwr == stop_at) return;
            end
            if (col_done) begin
                done_k = k;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic col_checks(input string t, input int exp_done, input int exp_col, input bit exp_ready);
        check({t, "_writes"}, nwr, 480);
        check({t, "_addr_errs"}, addr_errs, 0);
        check({t, "_data_errs"}, data_errs, 0);
        check({t, "_we_in_active"}, we_low_errs, 0);
        check({t, "_ready_busy"}, ready_errs, 0);
        check({t, "_first_lat"}, first_k, 1);
        if (exp_done >= 0) check({t, "_done_lat"}, done_k, exp_done);
        check({t, "_done_seen"}, 32'(col_done), 1);
        @(negedge clk);
        #1;
        check({t, "_done_pulse"}, 32'(col_done), 0);
        check({t, "_wr_col"}, 32'(wr_col), exp_col);
        check({t, "_ready_after"}, 32'(sample_ready), 32'(exp_ready));
    endtask

    initial begin
        int ecol, erow, ncols, werr, nw;
        rst = 1; sample_valid = 0; freeze = 0; vblank = 0; sample_data = 0;
        s_valid = 0; s_vblank = 1; s_freeze = 0; s_data = 0;
        repeat (3) @(negedge clk);
        sample_valid = 1;
        #1;
        check("rst_ready", 32'(sample_ready), 0);
        check("rst_we", 32'(fb_we), 0);
        check("rst_addr", 32'(fb_addr), 0);
        check("rst_wdata", 32'(fb_wdata), 0);
        check("rst_wr_col", 32'(wr_col), 0);
        check("rst_done", 32'(col_done), 0);
        sample_valid = 0;
        rst = 0;
        #1;
        check("rel_ready", 32'(sample_ready), 1);

        vblank = 1;
        send(8'd0);   watch(0, 478, 479, 0, 0, -1); col_checks("t1", 481, 1, 1);
        send(8'd128); watch(1, 239, 241, 1, 0, -1); col_checks("t3", -1, 2, 1);
        vblank = 1;
        send(8'd64);  watch(2, 359, 361, 0, 0, -1); col_checks("c2", 481, 3, 1);
        send(8'd1);   watch(3, 477, 479, 0, 0, -1); col_checks("c3", 481, 4, 1);
        send(8'd254); watch(4, 3, 5, 0, 0, -1);     col_checks("c4", 481, 5, 1);
        send(8'd255); watch(5, 1, 3, 0, 0, -1);     col_checks("t2", 481, 6, 1);

        send(8'd200); watch(6, 104, 106, 0, 0, 5);  col_checks("t5", 481, 7, 0);
        repeat (3) begin
            @(negedge clk);
            #1;
            check("t5_hold_ready", 32'(sample_ready), 0);
            check("t5_hold_we", 32'(fb_we), 0);
        end
        freeze = 0;
        #1;
        check("t5_release_ready", 32'(sample_ready), 1);
        @(negedge clk);
        sample_valid = 0;
        watch(7, 460, 462, 0, 201, -1);
        check("t5_pending_lat", first_k, 1);
        check("t6_rows_before_rst", nwr, 201);
        check("t6_errs_before_rst", addr_errs + data_errs, 0);

        rst = 1;
        #1;
        check("t6_we_in_rst", 32'(fb_we), 0);
        @(negedge clk);
        #1;
        check("t6_we_after", 32'(fb_we), 0);
        check("t6_wr_col", 32'(wr_col), 0);
        check("t6_addr", 32'(fb_addr), 0);
        check("t6_done", 32'(col_done), 0);
        rst = 0;
        #1;
        check("t6_ready", 32'(sample_ready), 1);
        send(8'd0); watch(0, 478, 479, 0, 0, -1); col_checks("t6_next", 481, 1, 1);

        ecol = 0; erow = 0; ncols = 0; werr = 0; nw = 0;
        s_valid = 1;
        for (int k = 0; k < 500 && ncols < 6; k++) begin
            @(negedge clk);
            #1;
            if (s_we) begin
                if (s_addr !== 4'(ecol + erow * 5)) werr++;
                if (s_wdata !== ((erow == 2) ? 12'h010 : 12'h000)) werr++;
                erow++;
                nw++;
            end
            if (s_done) begin
                if (erow != 3) werr++;
                ecol = (ecol == 4) ? 0 : ecol + 1;
                erow = 0;
                ncols++;
            end
        end
        s_valid = 0;
        check("t4_cols", ncols, 6);
        check("t4_writes", nw, 18);
        check("t4_errs", werr, 0);
        @(negedge clk);
        #1;
        check("t4_wr_col", 32'(s_col), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
